// File: rtl/strip_timestamp.sv
// Strips the trailing timestamp footer from an AXI4-Stream frame. The frame goes out on m_axis
// with tlast moved onto the last payload beat, and the footer goes out as one beat on m_ts.
module strip_timestamp #(
    parameter int C_AXIS_TDATA_WIDTH = 8,
    parameter int C_AXIS_TKEEP_WIDTH = C_AXIS_TDATA_WIDTH / 8,
    parameter int TIMESTAMP_WIDTH    = 72
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [C_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic [C_AXIS_TKEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    input  logic                          s_axis_tlast,
    output logic [C_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic [C_AXIS_TKEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast,
    output logic [TIMESTAMP_WIDTH-1:0]    m_ts_tdata,
    output logic                          m_ts_tvalid,
    input  logic                          m_ts_tready,
    output logic                          err_runt
);

    localparam int N      = TIMESTAMP_WIDTH / C_AXIS_TDATA_WIDTH;
    localparam int FILL_W = $clog2(N + 1);
    localparam logic [FILL_W-1:0] FULL = FILL_W'(N);

    logic [C_AXIS_TDATA_WIDTH-1:0] buf_data [N];
    logic [C_AXIS_TKEEP_WIDTH-1:0] buf_keep [N];
    logic [FILL_W-1:0]             fill;
    logic                          accept;
    logic                          full;
    logic [TIMESTAMP_WIDTH-1:0]    ts_next;

    // Stall input whenever either output register is occupied and not draining, so a new
    // timestamp can never overwrite one that has not yet been consumed.
    assign s_axis_tready = !rst && (!m_axis_tvalid || m_axis_tready) && (!m_ts_tvalid || m_ts_tready);
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign full          = (fill == FULL);

    // Footer is the N-1 newest buffered beats plus the incoming tlast beat, first beat in the MSBs.
    always_comb begin
        ts_next = '0;
        for (int i = 1; i < N; i++) begin
            ts_next[TIMESTAMP_WIDTH-1-(i-1)*C_AXIS_TDATA_WIDTH -: C_AXIS_TDATA_WIDTH] = buf_data[i];
        end
        ts_next[C_AXIS_TDATA_WIDTH-1:0] = s_axis_tdata;
    end

    // Entry 0 is always the oldest beat; once full the buffer shifts on every accepted beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                buf_data[i] <= '0;
                buf_keep[i] <= '0;
            end
            fill <= '0;
        end else if (accept) begin
            if (full) begin
                for (int i = 0; i < N - 1; i++) begin
                    buf_data[i] <= buf_data[i+1];
                    buf_keep[i] <= buf_keep[i+1];
                end
                buf_data[N-1] <= s_axis_tdata;
                buf_keep[N-1] <= s_axis_tkeep;
            end else if (!s_axis_tlast) begin
                buf_data[fill] <= s_axis_tdata;
                buf_keep[fill] <= s_axis_tkeep;
            end

            if (s_axis_tlast) begin
                fill <= '0;
            end else if (!full) begin
                fill <= fill + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tvalid <= 1'b0;
        end else if (accept && full) begin
            m_axis_tdata  <= buf_data[0];
            m_axis_tkeep  <= buf_keep[0];
            m_axis_tlast  <= s_axis_tlast;
            m_axis_tvalid <= 1'b1;
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ts_tdata  <= '0;
            m_ts_tvalid <= 1'b0;
        end else if (accept && full && s_axis_tlast) begin
            m_ts_tdata  <= ts_next;
            m_ts_tvalid <= 1'b1;
        end else if (m_ts_tready) begin
            m_ts_tvalid <= 1'b0;
        end
    end

    // A tlast arriving before the buffer is full means the packet had no payload beats.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_runt <= 1'b0;
        end else begin
            err_runt <= accept && s_axis_tlast && !full;
        end
    end

endmodule
